// File: rtl/wb_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_uart_fifo
// Description : Wishbone-attached UART with TX and RX FIFOs. 8N1-style
//               framing (1 start, DATA_BITS LSB-first, 1 stop, no parity),
//               bit period CLK_FREQ/BAUD_RATE clocks, level interrupt.
// Registers   : 0 DATA (wr: push TX, rd: pop RX), 1 STATUS, 2 CTRL, 3 COUNT
// Ports       : clk_i, rst_i (async, active high)
//               wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i[1:0], wb_dat_i[31:0]
//               wb_dat_o[31:0], wb_ack_o, wb_err_o, wb_stall_o (always 0)
//               rx_i (serial in), tx_o (serial out), irq_o (level interrupt)
// Options     : WB_UART_LOOPBACK_EN adds CTRL[2] internal loopback.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_uart_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 19200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_stall_o,
    input  logic        rx_i,
    output logic        tx_o,
    output logic        irq_o
);
    localparam int c_DIV   = CLK_FREQ / BAUD_RATE;
    localparam int c_CNT_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CW    = c_AW + 1;
    localparam logic [c_CNT_W-1:0] c_DIV_LAST  = c_CNT_W'(c_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_DIV / 2 - 1);
    localparam logic [c_CW-1:0]    c_FULL      = c_CW'(FIFO_DEPTH);
    localparam logic [2:0]         c_BIT_LAST  = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FIFO storage and pointers
    logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] r_rx_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
    logic [c_CW-1:0]      r_tx_cnt, r_rx_cnt;

    // Control / status
    logic [1:0]  r_ctrl;
    logic        r_overrun, r_frame_err, r_irq, r_ack, r_err;
    logic [31:0] r_dat;
    logic        w_loopback;

    // TX engine
    state_t               r_tx_state;
    logic [c_CNT_W-1:0]   r_tx_tick;
    logic [2:0]           r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_line;

    // RX engine
    state_t               r_rx_state;
    logic [c_CNT_W-1:0]   r_rx_tick;
    logic [2:0]           r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift, r_rx_byte;
    logic                 r_rx_s1, r_rx_s2, r_rx_prev, r_rx_push, r_frame_set;

    logic        w_req, w_wr, w_rd, w_sel_data, w_sel_stat, w_sel_ctrl;
    logic        w_tx_empty, w_tx_full, w_rx_empty, w_rx_full, w_tx_busy;
    logic        w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_wb_err, w_ovr_set;
    logic        w_rx_in;
    logic [31:0] w_status, w_count, w_rd_data;
    logic        w_unused;

    assign w_req      = wb_cyc_i & wb_stb_i;
    assign w_wr       = w_req & wb_we_i;
    assign w_rd       = w_req & ~wb_we_i;
    assign w_sel_data = (wb_adr_i == 2'd0);
    assign w_sel_stat = (wb_adr_i == 2'd1);
    assign w_sel_ctrl = (wb_adr_i == 2'd2);

    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == c_FULL);
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == c_FULL);
    assign w_tx_busy  = (r_tx_state != S_IDLE);

    // A DATA write into a full TX FIFO is refused with err and has no effect.
    assign w_wb_err  = w_wr & w_sel_data & w_tx_full;
    assign w_tx_push = w_wr & w_sel_data & ~w_tx_full;
    assign w_tx_pop  = (r_tx_state == S_IDLE) & ~w_tx_empty;
    assign w_rx_pop  = w_rd & w_sel_data & ~w_rx_empty;
    // A full RX FIFO still accepts a byte if a read frees a slot in that cycle.
    assign w_rx_push = r_rx_push & (~w_rx_full | w_rx_pop);
    assign w_ovr_set = r_rx_push & w_rx_full & ~w_rx_pop;

    assign w_status = {25'd0, r_frame_err, r_overrun, w_tx_busy, w_tx_full,
                       w_tx_empty, w_rx_full, w_rx_empty};
    assign w_count  = {7'd0, 9'(r_tx_cnt), 7'd0, 9'(r_rx_cnt)};

    always_comb begin
        w_rd_data = '0;
        case (wb_adr_i)
            2'd0:    w_rd_data = w_rx_empty ? 32'd0 : 32'(r_rx_mem[r_rx_rd]);
            2'd1:    w_rd_data = w_status;
            2'd2:    w_rd_data = {29'd0, w_loopback, r_ctrl};
            default: w_rd_data = w_count;
        endcase
    end

`ifdef WB_UART_LOOPBACK_EN
    logic r_loopback;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_loopback <= 1'b0;
        else if (w_wr && w_sel_ctrl)
            r_loopback <= wb_dat_i[2];
    end
    assign w_loopback = r_loopback;
`else
    assign w_loopback = 1'b0;
`endif

    assign w_rx_in    = w_loopback ? r_tx_line : r_rx_s2;
    assign tx_o       = r_tx_line | w_loopback;
    assign wb_dat_o   = r_dat;
    assign wb_ack_o   = r_ack;
    assign wb_err_o   = r_err;
    assign wb_stall_o = 1'b0;
    assign irq_o      = r_irq;
    assign w_unused   = &{1'b0, wb_dat_i};

    // FIFO storage: no reset needed, occupancy counters define validity.
    always_ff @(posedge clk_i) begin
        if (w_tx_push) r_tx_mem[r_tx_wr] <= wb_dat_i[DATA_BITS-1:0];
        if (w_rx_push) r_rx_mem[r_rx_wr] <= r_rx_byte;
    end

    // FIFO pointers, bus response and control/status registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tx_wr     <= '0;
            r_tx_rd     <= '0;
            r_tx_cnt    <= '0;
            r_rx_wr     <= '0;
            r_rx_rd     <= '0;
            r_rx_cnt    <= '0;
            r_ctrl      <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_irq       <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_dat       <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
            if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
            else if (w_tx_pop && !w_tx_push) r_tx_cnt <= r_tx_cnt - 1'b1;

            if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
            if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
            else if (w_rx_pop && !w_rx_push) r_rx_cnt <= r_rx_cnt - 1'b1;

            r_ack <= w_req & ~w_wb_err;
            r_err <= w_wb_err;
            r_dat <= w_rd ? w_rd_data : 32'd0;

            if (w_wr && w_sel_ctrl) r_ctrl <= wb_dat_i[1:0];

            // A new error event in the same cycle as a clear wins.
            r_overrun   <= w_ovr_set |
                           (r_overrun & ~(w_wr & w_sel_stat & wb_dat_i[5]));
            r_frame_err <= r_frame_set |
                           (r_frame_err & ~(w_wr & w_sel_stat & wb_dat_i[6]));

            r_irq <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_tx_empty) |
                     r_overrun | r_frame_err;
        end
    end

    // Transmitter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tx_state <= S_IDLE;
            r_tx_tick  <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_line  <= 1'b1;
        end else begin
            case (r_tx_state)
                S_IDLE: begin
                    r_tx_tick <= '0;
                    r_tx_line <= 1'b1;
                    if (w_tx_pop) begin
                        r_tx_shift <= r_tx_mem[r_tx_rd];
                        r_tx_line  <= 1'b0;
                        r_tx_state <= S_START;
                    end
                end
                S_START: begin
                    r_tx_tick <= r_tx_tick + 1'b1;
                    if (r_tx_tick == c_DIV_LAST) begin
                        r_tx_tick  <= '0;
                        r_tx_bit   <= '0;
                        r_tx_line  <= r_tx_shift[0];
                        r_tx_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    r_tx_tick <= r_tx_tick + 1'b1;
                    if (r_tx_tick == c_DIV_LAST) begin
                        r_tx_tick <= '0;
                        if (r_tx_bit == c_BIT_LAST) begin
                            r_tx_line  <= 1'b1;
                            r_tx_state <= S_STOP;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_line  <= r_tx_shift[1];
                        end
                    end
                end
                default: begin
                    r_tx_tick <= r_tx_tick + 1'b1;
                    if (r_tx_tick == c_DIV_LAST) begin
                        r_tx_tick  <= '0;
                        r_tx_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Receiver. A start needs a falling edge, so a held-low line after a
    // framing error is not mistaken for a new start bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_rx_state  <= S_IDLE;
            r_rx_tick   <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_byte   <= '0;
            r_rx_push   <= 1'b0;
            r_frame_set <= 1'b0;
        end else begin
            r_rx_s1     <= rx_i;
            r_rx_s2     <= r_rx_s1;
            r_rx_prev   <= w_rx_in;
            r_rx_push   <= 1'b0;
            r_frame_set <= 1'b0;
            case (r_rx_state)
                S_IDLE: begin
                    r_rx_tick <= '0;
                    if (r_rx_prev && !w_rx_in) r_rx_state <= S_START;
                end
                S_START: begin
                    r_rx_tick <= r_rx_tick + 1'b1;
                    if (r_rx_tick == c_HALF_LAST) begin
                        r_rx_tick  <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= w_rx_in ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    r_rx_tick <= r_rx_tick + 1'b1;
                    if (r_rx_tick == c_DIV_LAST) begin
                        r_rx_tick  <= '0;
                        r_rx_shift <= {w_rx_in, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == c_BIT_LAST) r_rx_state <= S_STOP;
                        else                        r_rx_bit   <= r_rx_bit + 1'b1;
                    end
                end
                default: begin
                    r_rx_tick <= r_rx_tick + 1'b1;
                    if (r_rx_tick == c_DIV_LAST) begin
                        r_rx_tick  <= '0;
                        r_rx_state <= S_IDLE;
                        if (w_rx_in) begin
                            r_rx_byte <= r_rx_shift;
                            r_rx_push <= 1'b1;
                        end else begin
                            r_frame_set <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_uart_fifo
// Description : Self-checking bench for wb_uart_fifo. Bus responses are
//               checked by a scoreboard monitor; serial line, interrupt and
//               reset behaviour are checked directly. DUT runs with
//               CLK_FREQ=1000, BAUD_RATE=60 so the bit period is 16 clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_uart_fifo;
    localparam int DIV = 16;  // 1000/60 truncated

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [1:0]  wb_adr_i = 2'd0;
    logic [31:0] wb_dat_i = 32'd0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o, wb_stall_o;
    logic        rx_i = 1'b1;
    logic        tx_o, irq_o;

    wb_uart_fifo #(
        .CLK_FREQ  (1000),
        .BAUD_RATE (60),
        .DATA_BITS (8),
        .FIFO_DEPTH(16)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_we_i   (wb_we_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .wb_err_o  (wb_err_o),
        .wb_stall_o(wb_stall_o),
        .rx_i      (rx_i),
        .tx_o      (tx_o),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic [7:0] rx_vec [0:16];

    // Scoreboard monitor: one expected entry per bus termination.
    always @(negedge clk_i) begin : mon
        exp_t e;
        if (!rst_i && (wb_ack_o || wb_err_o)) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_term: ack=%0b err=%0b with nothing outstanding",
                         wb_ack_o, wb_err_o);
            end else begin
                e = sb.pop_front();
                if ((wb_ack_o && wb_err_o) || (wb_err_o != e.err) ||
                    (e.chk && (wb_dat_o !== e.data))) begin
                    n_fail++;
                    $display("FAIL %s: got ack=%0b err=%0b dat=%08h, want err=%0b dat=%08h",
                             e.name, wb_ack_o, wb_err_o, wb_dat_o, e.err, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                           input logic exp_err, input logic chk, input logic [31:0] exp,
                           input string name);
        exp_t e;
        e.err = exp_err; e.chk = chk; e.data = exp; e.name = name;
        sb.push_back(e);
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        repeat (2) @(negedge clk_i);
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no bus termination within 2 cycles", name);
            sb.delete();
        end
    endtask

    task automatic wr(input logic [1:0] adr, input logic [31:0] dat, input string name);
        wb_xfer(1'b1, adr, dat, 1'b0, 1'b0, 32'd0, name);
    endtask

    task automatic wr_err(input logic [1:0] adr, input logic [31:0] dat, input string name);
        wb_xfer(1'b1, adr, dat, 1'b1, 1'b0, 32'd0, name);
    endtask

    task automatic rd(input logic [1:0] adr, input logic [31:0] exp, input string name);
        wb_xfer(1'b0, adr, 32'd0, 1'b0, 1'b1, exp, name);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(posedge clk_i); #1;
        rx_i = 1'b0;
        repeat (DIV) @(posedge clk_i);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (DIV) @(posedge clk_i);
            #1;
        end
        rx_i = stop;
        repeat (DIV) @(posedge clk_i);
        #1;
        rx_i = 1'b1;
        repeat (4) @(posedge clk_i);
    endtask

    task automatic wait_tx_low(input string name);
        int n;
        n = 0;
        while (tx_o !== 1'b0 && n < 20 * DIV) begin
            @(negedge clk_i);
            n++;
        end
        check(name, {31'd0, tx_o}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, n_low;
        logic lvl;
        rx_vec[0]  = 8'h00; rx_vec[1]  = 8'hFF; rx_vec[2]  = 8'h01; rx_vec[3]  = 8'h80;
        rx_vec[4]  = 8'h5A; rx_vec[5]  = 8'hA5; rx_vec[6]  = 8'h12; rx_vec[7]  = 8'h34;
        rx_vec[8]  = 8'h56; rx_vec[9]  = 8'h78; rx_vec[10] = 8'h9A; rx_vec[11] = 8'hBC;
        rx_vec[12] = 8'hDE; rx_vec[13] = 8'hF0; rx_vec[14] = 8'h0F; rx_vec[15] = 8'hC3;
        rx_vec[16] = 8'h7E;

        // Reset state: {tx, ack, err, stall, irq} = 1_0000, dat = 0
        repeat (3) @(negedge clk_i);
        check("reset_ctl", {27'd0, tx_o, wb_ack_o, wb_err_o, wb_stall_o, irq_o}, 32'h10);
        check("reset_dat", wb_dat_o, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        rd(2'd1, 32'h05, "status_after_reset");
        rd(2'd2, 32'h00, "ctrl_after_reset");
        rd(2'd3, 32'h00, "count_after_reset");

        // TX 0x55: 0,1,0,1,0,1,0,1,0 each DIV clocks, then stop 1
        wr(2'd0, 32'h55, "tx55_write");
        wait_tx_low("tx55_start_seen");
        for (int s = 0; s < 9; s++) begin
            lvl = tx_o;
            check("tx55_level", {31'd0, lvl}, {31'd0, 1'(s % 2)});
            len = 0;
            while (tx_o === lvl && len < 4 * DIV) begin
                len++;
                @(negedge clk_i);
            end
            check("tx55_bit_len", len, DIV);
        end
        n_low = 0;
        repeat (DIV + 2) begin
            if (tx_o !== 1'b1) n_low++;
            @(negedge clk_i);
        end
        check("tx55_stop_high", n_low, 0);
        rd(2'd1, 32'h05, "tx55_status_idle");

        // RX 0xA3
        send_rx(8'hA3, 1'b1);
        rd(2'd3, 32'h0000_0001, "rxA3_count");
        rd(2'd0, 32'h0000_00A3, "rxA3_data");
        rd(2'd1, 32'h05, "rxA3_status_empty");
        rd(2'd0, 32'h0000_0000, "rx_empty_read_zero");
        rd(2'd3, 32'h0000_0000, "rx_empty_count");

        // CTRL bits and tx_irq_en
        wr(2'd2, 32'hFFFF_FFFF, "ctrl_write_all");
`ifdef WB_UART_LOOPBACK_EN
        rd(2'd2, 32'h07, "ctrl_readback");
`else
        rd(2'd2, 32'h03, "ctrl_readback");
`endif
        repeat (2) @(negedge clk_i);
        check("irq_tx_empty", {31'd0, irq_o}, 32'd1);
        wr(2'd2, 32'h0, "ctrl_clear");
        repeat (2) @(negedge clk_i);
        check("irq_off", {31'd0, irq_o}, 32'd0);

        // rx_irq_en, then a frame with stop bit 0
        wr(2'd2, 32'h1, "ctrl_rx_irq");
        send_rx(8'h3C, 1'b1);
        check("irq_rx_data", {31'd0, irq_o}, 32'd1);
        send_rx(8'h81, 1'b0);
        rd(2'd1, 32'h44, "ferr_status");
        rd(2'd3, 32'h01, "ferr_count");
        rd(2'd0, 32'h3C, "ferr_data_intact");
        wr(2'd1, 32'h40, "ferr_clear");
        rd(2'd1, 32'h05, "ferr_cleared");
        repeat (2) @(negedge clk_i);
        check("ferr_irq_off", {31'd0, irq_o}, 32'd0);
        wr(2'd2, 32'h0, "ctrl_clear2");

        // 17 frames into a 16-deep RX FIFO
        for (int i = 0; i < 16; i++) send_rx(rx_vec[i], 1'b1);
        check("ovr_irq_before", {31'd0, irq_o}, 32'd0);
        rd(2'd1, 32'h06, "ovr_status_full");
        send_rx(rx_vec[16], 1'b1);
        rd(2'd1, 32'h26, "ovr_status");
        rd(2'd3, 32'h10, "ovr_count");
        check("ovr_irq", {31'd0, irq_o}, 32'd1);
        for (int i = 0; i < 16; i++) rd(2'd0, {24'd0, rx_vec[i]}, "ovr_data");
        wr(2'd1, 32'h20, "ovr_clear");
        rd(2'd1, 32'h05, "ovr_cleared");
        repeat (2) @(negedge clk_i);
        check("ovr_irq_off", {31'd0, irq_o}, 32'd0);

        // TX FIFO overflow while transmitter busy
        wr(2'd0, 32'h00, "txfull_first");
        repeat (5) @(posedge clk_i);
        for (int i = 0; i < 16; i++) wr(2'd0, 32'(i + 1), "txfull_fill");
        wr_err(2'd0, 32'hEE, "txfull_overflow");
        rd(2'd1, 32'h19, "txfull_status");
        rd(2'd3, 32'h0010_0000, "txfull_count");

        // Reset in the middle of a frame
        wait_tx_low("rst_mid_tx_low");
        #1;
        rst_i = 1'b1;
        #1;
        check("rst_tx_async", {31'd0, tx_o}, 32'd1);
        check("rst_outputs_async", {wb_dat_o[30:0], wb_ack_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        rd(2'd1, 32'h05, "rst_status_tx_empty");
        rd(2'd3, 32'h00, "rst_count");
        n_low = 0;
        repeat (12 * DIV) begin
            @(negedge clk_i);
            if (tx_o !== 1'b1) n_low++;
        end
        check("rst_tx_quiet", n_low, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_uart_fifo.md
WB_UART_FIFO -- requirements
Module: wb_uart_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 19200, line rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, range 5..8, payload bits per frame.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, power of two 2..256, entries per TX and RX FIFO.
REQ-005 SHALL have port clk_i, input, 1, sole clock; all logic is rising-edge.
REQ-006 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports wb_cyc_i and wb_stb_i, input, 1 each, Wishbone cycle and strobe.
REQ-008 SHALL have port wb_we_i, input, 1, write enable.
REQ-009 SHALL have port wb_adr_i, input, 2, word register index.
REQ-010 SHALL have port wb_dat_i, input, 32, write data.
REQ-011 SHALL have port wb_dat_o, output, 32, read data.
REQ-012 SHALL have ports wb_ack_o and wb_err_o, output, 1 each, transfer termination.
REQ-013 SHALL have port wb_stall_o, output, 1, tied 0.
REQ-014 SHALL have port rx_i, input, 1, serial in, idle high.
REQ-015 SHALL have port tx_o, output, 1, serial out, idle high.
REQ-016 SHALL have port irq_o, output, 1, level interrupt.

Function
REQ-017 SHALL use frame: 1 start (0), DATA_BITS LSB-first, 1 stop (1), no parity; bit period DIV = CLK_FREQ/BAUD_RATE (integer truncation).
REQ-018 SHALL map registers: 0 DATA (write pushes TX FIFO, read pops RX FIFO), 1 STATUS, 2 CTRL, 3 COUNT.
REQ-019 SHALL define STATUS bits: [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] tx_busy, [5] overrun (sticky), [6] frame_err (sticky); writing 1 to bit 5 or 6 clears it.
REQ-020 SHALL define CTRL bits: [0] rx_irq_en, [1] tx_irq_en; other bits read 0.
REQ-021 SHALL define COUNT: [8:0] RX occupancy, [24:16] TX occupancy.
REQ-022 SHALL terminate each cyc&stb cycle with exactly one of ack/err, one cycle later; single-cycle pulse.
REQ-023 SHALL assert err (not ack) on DATA write with TX full; data dropped, no state change.
REQ-024 SHALL ack DATA read with RX empty, returning 0, no pop.
REQ-025 SHALL zero-extend DATA reads above DATA_BITS.
REQ-026 SHALL run TX FSM IDLE->START->DATA->STOP->IDLE, each state DIV cycles; leave IDLE on the cycle after tx FIFO non-empty, popping one entry; tx_busy high outside IDLE.
REQ-027 SHALL run RX FSM IDLE->START->DATA->STOP; rx_i double-flop synchronised; START checks line still low at DIV/2, else return to IDLE; data and stop sampled at bit centres.
REQ-028 SHALL, on stop sample 0, set frame_err and discard byte.
REQ-029 SHALL, on valid byte with RX full, set overrun and discard byte; FIFO contents unchanged.
REQ-030 SHALL allow simultaneous push and pop on a full or empty FIFO with occupancy preserved and data correct; pointers wrap modulo FIFO_DEPTH.
REQ-031 SHALL drive irq_o = (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty) | overrun | frame_err, registered.

Reset
REQ-032 SHALL, on rst_i, immediately force tx_o=1, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, irq_o=0, FIFOs empty, both FSMs IDLE, STATUS sticky bits and CTRL 0.
REQ-033 SHALL abort any frame in flight on reset; no partial byte enters RX FIFO.

Configuration
REQ-034 SHALL, with WB_UART_LOOPBACK_EN defined, add CTRL[2] loopback: when 1 RX input is internal tx line and tx_o held 1.
REQ-035 SHALL, without WB_UART_LOOPBACK_EN, have CTRL[2] read 0, writes ignored, rx_i always used.

Verification
REQ-036 SHALL check: write 0x55 to DATA -> tx_o emits 0,1,0,1,0,1,0,1,0,1 each 2604 cycles; tx_busy then 0.
REQ-037 SHALL check: drive 0xA3 on rx_i -> COUNT[8:0]=1, DATA read 0xA3, then rx_empty=1.
REQ-038 SHALL check: FIFO_DEPTH+1 writes while TX stalled by busy -> last write err, first FIFO_DEPTH ack, tx_full=1.
REQ-039 SHALL check: 17 RX frames with no reads (depth 16) -> overrun=1, irq_o=1, first 16 bytes read intact; write 0x20 to STATUS clears overrun.
REQ-040 SHALL check: RX frame with stop bit 0 -> frame_err=1, RX FIFO unchanged.
REQ-041 SHALL check: rst_i mid TX frame -> tx_o=1 same cycle, tx_empty=1, no further bits.
